// File: rtl/irda_tx_fifo.sv
// IrDA transmit register block: TXDATA byte FIFO drained by the serializer,
// plus STATUS/THRESH/CTRL registers and a level interrupt.
module irda_tx_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [3:0]  THRESH_RST = 4'd2
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic        wb_ack_o,
    input  logic [1:0]  wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        irq_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [LVL_W-1:0]      level, level_next;
    logic                  overflow;
    logic [3:0]            thresh;
    logic                  ien;

    logic wr, rd, full, empty, push, pop, flush, ovf_set, ovf_clr;
    logic [7:0] status;

    assign wr      = we_i & wb_ack_o;
    assign rd      = re_i & wb_ack_o;
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign pop     = tx_valid_o & tx_ready_i;
    assign push    = wr & (wb_adr_i == 2'd0) & (~full | pop);
    assign flush   = wr & (wb_adr_i == 2'd3) & wb_dat_i[1];
    assign ovf_set = wr & (wb_adr_i == 2'd0) & full & ~pop;
    assign ovf_clr = rd & (wb_adr_i == 2'd1);

    assign tx_valid_o = ~empty;
    assign tx_data_o  = mem[rd_ptr];
    assign status     = {overflow, full, empty, 5'(level)};

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (flush) begin
            // flush wins over any push/pop landing in the same cycle
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_next = rd_ptr + PTR_ONE;
            if (push && !pop)
                level_next = level + LVL_ONE;
            else if (pop && !push)
                level_next = level - LVL_ONE;
        end
    end

    always_comb begin
        wb_dat_o = 8'h00;
        case (wb_adr_i)
            2'd1:    wb_dat_o = status;
            2'd2:    wb_dat_o = {4'h0, thresh};
            2'd3:    wb_dat_o = {7'h00, ien};
            default: wb_dat_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wb_dat_i;
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            thresh   <= THRESH_RST;
            ien      <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            // a fresh overflow beats the clearing STATUS read
            overflow <= ovf_set | (overflow & ~ovf_clr);
            irq_o    <= ien & (5'(level_next) <= {1'b0, thresh});
            if (wr && wb_adr_i == 2'd2)
                thresh <= wb_dat_i[3:0];
            if (wr && wb_adr_i == 2'd3)
                ien <= wb_dat_i[0];
        end
    end
endmodule

// File: tb/tb_irda_tx_fifo.sv
// Bench for irda_tx_fifo: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_irda_tx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b0, we_i = 1'b0, re_i = 1'b0, wb_ack_o = 1'b0;
    logic [1:0] wb_adr_i = 2'd0;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o, tx_data_o;
    logic       tx_valid_o, tx_ready_i = 1'b0, irq_o;

    irda_tx_fifo #(.DEPTH_LOG2(4), .THRESH_RST(4'd2)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .we_i(we_i), .re_i(re_i),
        .wb_ack_o(wb_ack_o), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // reference model
    logic [7:0] q[$];
    logic       m_ovf, m_ien, m_irq, model_ok = 1'b0;
    logic [3:0] m_thresh;

    logic       rdy_g = 1'b0;
    logic [7:0] last_rd, last_data;
    logic       last_valid, last_irq;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int n = q.size();
        return {m_ovf, n == DEPTH, n == 0, 5'(n)};
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] adr);
        case (adr)
            2'd1:    return m_status();
            2'd2:    return {4'h0, m_thresh};
            2'd3:    return {7'h00, m_ien};
            default: return 8'h00;
        endcase
    endfunction

    task automatic step(input logic rst, input logic we, input logic re, input logic ack,
                        input logic [1:0] adr, input logic [7:0] dat, input logic rdy);
        logic pop, wr, rd, accept, ovf_set, flush, ien_old;
        logic [3:0] th_old;
        @(negedge clk);
        wb_rst_i = rst; we_i = we; re_i = re; wb_ack_o = ack;
        wb_adr_i = adr; wb_dat_i = dat; tx_ready_i = rdy;
        #1;
        last_rd = wb_dat_o; last_data = tx_data_o;
        last_valid = tx_valid_o; last_irq = irq_o;
        if (model_ok) begin
            check_val("tx_valid", {7'h0, tx_valid_o}, {7'h0, q.size() != 0});
            if (q.size() != 0) check_val("tx_data", tx_data_o, q[0]);
            check_val("irq", {7'h0, irq_o}, {7'h0, m_irq});
            if (re && ack) check_val("rdata", wb_dat_o, m_read(adr));
        end
        pop = (q.size() != 0) && rdy;
        wr  = we && ack;
        rd  = re && ack;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_ien = 1'b0; m_irq = 1'b0; m_thresh = 4'd2;
            model_ok = 1'b1;
        end else begin
            ien_old = m_ien; th_old = m_thresh;
            flush   = wr && adr == 2'd3 && dat[1];
            ovf_set = wr && adr == 2'd0 && q.size() == DEPTH && !pop;
            accept  = wr && adr == 2'd0 && (q.size() < DEPTH || pop);
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (accept) q.push_back(dat);
            end
            m_irq = ien_old && (q.size() <= int'(th_old));
            if (rd && adr == 2'd1) m_ovf = 1'b0;
            if (ovf_set) m_ovf = 1'b1;
            if (wr && adr == 2'd2) m_thresh = dat[3:0];
            if (wr && adr == 2'd3) m_ien = dat[0];
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, rdy_g);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, rdy_g);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, rdy_g);
    endtask

    task automatic bus_wr(input logic [1:0] adr, input logic [7:0] dat);
        step(1'b0, 1'b1, 1'b0, 1'b0, adr, dat, rdy_g);
        step(1'b0, 1'b1, 1'b0, 1'b1, adr, dat, rdy_g);
    endtask

    task automatic bus_rd(input logic [1:0] adr, output logic [7:0] rdata);
        step(1'b0, 1'b0, 1'b1, 1'b0, adr, 8'h00, rdy_g);
        step(1'b0, 1'b0, 1'b1, 1'b1, adr, 8'h00, rdy_g);
        rdata = last_rd;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] drained [16];
        logic       irq_mid;

        // 1) reset state, single byte
        do_reset();
        bus_rd(2'd1, r);
        check_val("rst_status", r, 8'h20);
        check_val("rst_valid", {7'h0, last_valid}, 8'h00);
        bus_wr(2'd0, 8'hA5);
        idle();
        check_val("t1_valid", {7'h0, last_valid}, 8'h01);
        check_val("t1_data", last_data, 8'hA5);
        bus_rd(2'd1, r);
        check_val("t1_status", r, 8'h01);

        // 2) fill to full, overflow, sticky clear on read
        do_reset();
        for (int i = 0; i < 16; i++) bus_wr(2'd0, 8'(i));
        bus_rd(2'd1, r);
        check_val("t2_full", r, 8'h50);
        bus_wr(2'd0, 8'hFF);
        bus_rd(2'd1, r);
        check_val("t2_ovf", r, 8'hD0);
        bus_rd(2'd1, r);
        check_val("t2_ovf_clr", r, 8'h50);

        // 3) push while full with simultaneous pop
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h77, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h77, 1'b1);
        bus_rd(2'd1, r);
        check_val("t3_status", r, 8'h50);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
            drained[i] = last_data;
        end
        check_val("t3_first", drained[0], 8'h01);
        check_val("t3_mid", drained[14], 8'h0F);
        check_val("t3_last", drained[15], 8'h77);
        bus_rd(2'd1, r);
        check_val("t3_empty", r, 8'h20);

        // 4) threshold interrupt
        do_reset();
        bus_wr(2'd2, 8'h03);
        bus_wr(2'd3, 8'h01);
        for (int i = 0; i < 5; i++) bus_wr(2'd0, 8'(8'h40 + i));
        idle();
        check_val("t4_irq_lo", {7'h0, last_irq}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        irq_mid = last_irq;
        check_val("t4_irq_lvl4", {7'h0, irq_mid}, 8'h00);
        idle();
        check_val("t4_irq_hi", {7'h0, last_irq}, 8'h01);

        // 5) flush concurrent with a pop, then refill
        do_reset();
        for (int i = 0; i < 6; i++) bus_wr(2'd0, 8'(8'h10 + i));
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h02, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h02, 1'b1);
        bus_rd(2'd1, r);
        check_val("t5_flush_valid", {7'h0, last_valid}, 8'h00);
        check_val("t5_flush_status", r, 8'h20);
        bus_wr(2'd3, 8'h00);
        bus_wr(2'd0, 8'h3C);
        idle();
        check_val("t5_refill", last_data, 8'h3C);

        // 6) reset mid-stream
        do_reset();
        bus_wr(2'd2, 8'h0F);
        bus_wr(2'd3, 8'h01);
        for (int i = 0; i < 9; i++) bus_wr(2'd0, 8'(8'h80 + i));
        rdy_g = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        idle();
        check_val("t6_valid", {7'h0, last_valid}, 8'h00);
        check_val("t6_irq", {7'h0, last_irq}, 8'h00);
        bus_rd(2'd1, r);
        check_val("t6_status", r, 8'h20);
        bus_rd(2'd2, r);
        check_val("t6_thresh", r, 8'h02);
        rdy_g = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int op;
            logic [1:0] adr;
            logic [7:0] dat;
            op  = int'($urandom_range(0, 9));
            adr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) adr = 2'd0;
            dat = 8'($urandom);
            if (adr == 2'd3 && $urandom_range(0, 7) != 0) dat[1] = 1'b0;
            step($urandom_range(0, 299) == 0,
                 op < 6, op >= 6 && op < 8, $urandom_range(0, 1) == 1,
                 adr, dat, $urandom_range(0, 9) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
